univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
- REQ-001 Parameter WIDTH, default 8, register width in bits (WIDTH >= 2) SHALL be supported.
- REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), burst-count width SHALL be supported.
- REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004 rst_n  input  1  reset, asynchronous, active-low.
- REQ-005 mode  input  3  operation: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110/111 reserved (treated as HOLD).
- REQ-006 en  input  1  single-step enable.
- REQ-007 d  input  WIDTH  parallel load data.
- REQ-008 sin_r  input  1  serial bit entering q[0] on SHL.
- REQ-009 sin_l  input  1  serial bit entering q[WIDTH-1] on SHR.
- REQ-010 start  input  1  burst request; uses mode and shamt.
- REQ-011 shamt  input  CNT_W  burst shift count.
- REQ-012 q  output  WIDTH  register contents.
- REQ-013 so_msb / so_lsb  output  1 each  equal to q[WIDTH-1] / q[0], driven directly from the register.
- REQ-014 busy  output  1  burst in progress.
- REQ-015 done  output  1  one-cycle burst-complete pulse.

Function
- REQ-016 FSM states SHALL be IDLE, SHIFT and DONE; busy=1 only in SHIFT and done=1 only in DONE.
- REQ-017 In IDLE with start=0 and en=1, one step per edge: LOAD q<=d; SHL q<={q[W-2:0],sin_r}; SHR q<={sin_l,q[W-1:1]}; ROTL q<={q[W-2:0],q[W-1]}; ROTR q<={q[0],q[W-1:1]}; HOLD/reserved unchanged.
- REQ-018 In IDLE with en=0 and start=0, q SHALL hold.
- REQ-019 In IDLE, start=1 with mode in {SHL,SHR,ROTL,ROTR} SHALL be accepted; mode and shamt latched; en ignored that cycle; q unchanged on the accept edge.
- REQ-020 On accept with shamt>0, FSM SHALL go to SHIFT with counter=shamt; with shamt=0, it SHALL go directly to DONE with q unchanged.
- REQ-021 In SHIFT, each edge SHALL perform one step of the latched mode, sampling sin_r/sin_l live, and decrement the counter; after the step with counter=1, FSM SHALL go to DONE.
- REQ-022 Burst latency: the final q value SHALL be visible N edges after the accept edge, and done SHALL be high during the following cycle; DONE SHALL return to IDLE unconditionally.
- REQ-023 start with mode HOLD, LOAD or reserved SHALL be ignored (no state change), and en SHALL then behave as in REQ-017.
- REQ-024 start and en SHALL be ignored in SHIFT and DONE; input mode changes during a burst SHALL have no effect.
- REQ-025 shamt >= WIDTH SHALL be honoured literally: shifts fill with serial input, rotates wrap modulo WIDTH.

Reset
- REQ-026 rst_n=0 SHALL immediately force q=0, counter=0, FSM=IDLE, busy=0, done=0, independent of clk.
- REQ-027 Reset asserted mid-burst SHALL abort the burst without a done pulse.
- REQ-028 After rst_n deasserts, the first edge SHALL behave as an IDLE cycle.

Structure
- REQ-029 The mode encodings and FSM state encodings SHALL be defined in shared package univ_shift_pkg.
- REQ-030 The one-step next-value logic SHALL be a combinational sub-module usr_step (inputs q, mode, sin_r, sin_l; output next q), shared by the single-step and burst paths.
- REQ-031 The top SHALL contain only the FSM, the counter and the WIDTH-bit register.

Verification (WIDTH=8)
- REQ-032 Reset: rst_n=0 mid-cycle -> q=00, busy=0 and done=0 without a clock edge.
- REQ-033 Single step: LOAD d=A5 en=1 -> q=A5; then SHL sin_r=1 -> 4B; reload A5, SHR sin_l=0 -> 52; HOLD -> 52 retained.
- REQ-034 Burst rotate: q=81, start ROTL shamt=3 -> busy for 3 cycles, q 03/06/0C, done high one cycle after, then IDLE.
- REQ-035 Zero count: start SHR shamt=0 -> done pulses on the next cycle, busy never high, q unchanged.
- REQ-036 Collisions: start and en together in IDLE -> burst wins; start/en during SHIFT -> ignored, count unaffected; start with LOAD -> ignored, en=1 loads d.
- REQ-037 Abort: rst_n=0 after 2 of 5 SHL shifts -> q=00, IDLE, no done pulse; a new burst after release completes normally.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: operation modes,
// burst FSM states and the test for modes that may start a burst.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Only the four shift/rotate modes can run as a multi-step burst.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// One-step next-value logic of the shift register; purely combinational and
// shared by the single-step and burst paths.
module usr_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q_step
);

    always_comb begin
        q_step = q;
        case (mode)
            MODE_LOAD: q_step = d;
            MODE_SHL:  q_step = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  q_step = {sin_l, q[WIDTH-1:1]};
            MODE_ROTL: q_step = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR: q_step = {q[0], q[WIDTH-1:1]};
            default:   q_step = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operation and a counted burst
// mode driven by a three-state FSM (IDLE -> SHIFT -> DONE).
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic [2:0]         mode_reg, mode_next;
    logic [2:0]         step_mode;
    logic [WIDTH-1:0]   step_q;

    // During a burst the latched mode drives the step, so live mode changes
    // cannot disturb it.
    assign step_mode = (state_reg == ST_SHIFT) ? mode_reg : mode;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_reg),
        .mode   (step_mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q_step (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            q_reg     <= '0;
            mode_reg  <= MODE_HOLD;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        mode_next  = mode_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && is_burst_mode(mode)) begin
                    // Accept edge: latch the burst, leave q untouched.
                    mode_next = mode;
                    if (shamt == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SHIFT;
                        cnt_next   = shamt;
                    end
                end else if (en) begin
                    q_next = step_q;
                end
            end
            ST_SHIFT: begin
                q_next   = step_q;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign q      = q_reg;
    assign so_msb = q_reg[WIDTH-1];
    assign so_lsb = q_reg[0];
    assign busy   = (state_reg == ST_SHIFT);
    assign done   = (state_reg == ST_DONE);

endmodule
